// File: rtl/regfile_dbg_pkg.sv
// Shared types and defaults for the register-bank debug dump reader.
// The state encoding is fixed at 2 bits so trace tooling can decode it.
package regfile_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int REG_COUNT      = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a register-bank read port over FIRST_REG..LAST_REG and streams
// {address, data} beats out on a valid/ready channel for debug/trace.
module regfile_dump_reader
  import regfile_dbg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = REG_COUNT - 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ABORT,
  output logic [ADDR_WIDTH-1:0] RA,
  input  logic [DATA_WIDTH-1:0] RD,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [ADDR_WIDTH-1:0] OUT_ADDR,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [ADDR_WIDTH-1:0] LP_FIRST = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(LAST_REG);
  localparam logic [ADDR_WIDTH-1:0] LP_ONE   = ADDR_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [ADDR_WIDTH-1:0]   w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   r_out_addr;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    w_cap;
  logic                    w_busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= LP_FIRST;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cap) begin
        r_out_addr <= r_cnt;
        r_out_data <= RD;
      end
    end
  end

  // Last-register test happens before the increment, so r_cnt never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (START) begin
          w_state_nxt = READ;
          w_cnt_nxt   = LP_FIRST;
        end
      end
      READ: begin
        if (ABORT) begin
          w_state_nxt = IDLE;
        end else begin
          w_cap       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (ABORT) begin
          w_state_nxt = IDLE;
        end else if (OUT_READY) begin
          if (r_cnt == LP_LAST) begin
            w_state_nxt = FINISH;
          end else begin
            w_cnt_nxt   = r_cnt + LP_ONE;
            w_state_nxt = READ;
          end
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_busy    = (r_state == READ) || (r_state == SEND);
  assign BUSY      = w_busy;
  assign RA        = w_busy ? r_cnt : '0;
  assign OUT_VALID = (r_state == SEND);
  assign OUT_ADDR  = r_out_addr;
  assign OUT_DATA  = r_out_data;
  assign DONE      = (r_state == FINISH);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader beside a small 32x32 register bank.
// Beats are collected by a stream monitor and compared to a bank model.
module tb_regfile_dump_reader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        OUT_READY = 1'b1;
  logic [4:0]  RA;
  logic [31:0] RD;
  logic        OUT_VALID;
  logic [4:0]  OUT_ADDR;
  logic [31:0] OUT_DATA;
  logic        BUSY;
  logic        DONE;

  logic        START7 = 1'b0;
  logic        ABORT7 = 1'b0;
  logic        READY7 = 1'b1;
  logic [4:0]  RA7;
  logic [31:0] RD7;
  logic        VALID7;
  logic [4:0]  ADDR7;
  logic [31:0] DATA7;
  logic        BUSY7;
  logic        DONE7;

  always #5 CLK = ~CLK;

  // register bank: x0 hard-wired to zero, one write port
  logic [31:0] bank [32];
  logic        bank_clr = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;

  always @(posedge CLK) begin
    if (bank_clr) begin
      for (int i = 0; i < 32; i++) bank[i] <= '0;
    end else if (we && wa != 5'd0) begin
      bank[wa] <= wd;
    end
  end

  assign RD  = (RA == 5'd0) ? 32'd0 : bank[RA];
  assign RD7 = (RA7 == 5'd0) ? 32'd0 : bank[RA7];

  regfile_dump_reader u_dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .RA(RA), .RD(RD),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_ADDR(OUT_ADDR), .OUT_DATA(OUT_DATA),
    .BUSY(BUSY), .DONE(DONE)
  );

  regfile_dump_reader #(.FIRST_REG(7), .LAST_REG(7)) u_dut7 (
    .CLK(CLK), .RST(RST), .START(START7), .ABORT(ABORT7),
    .RA(RA7), .RD(RD7),
    .OUT_VALID(VALID7), .OUT_READY(READY7),
    .OUT_ADDR(ADDR7), .OUT_DATA(DATA7),
    .BUSY(BUSY7), .DONE(DONE7)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // stream monitor, sampled on the falling edge
  logic [4:0]  qa [$];
  logic [31:0] qd [$];
  logic [4:0]  q7a [$];
  logic [31:0] q7d [$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          done7_cnt = 0;
  int          cyc = 0;
  logic        p_stall = 1'b0;
  logic [4:0]  p_addr = '0;
  logic [31:0] p_data = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (p_stall) begin
      chk("stall_valid", 64'(OUT_VALID), 64'd1);
      chk("stall_addr", 64'(OUT_ADDR), 64'(p_addr));
      chk("stall_data", 64'(OUT_DATA), 64'(p_data));
    end
    p_stall = OUT_VALID && !OUT_READY && !ABORT && !RST;
    p_addr  = OUT_ADDR;
    p_data  = OUT_DATA;
    if (OUT_VALID && OUT_READY && !RST) begin
      qa.push_back(OUT_ADDR);
      qd.push_back(OUT_DATA);
    end
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (VALID7 && READY7 && !RST) begin
      q7a.push_back(ADDR7);
      q7d.push_back(DATA7);
    end
    if (DONE7) done7_cnt++;
  end

  logic [31:0] m [32];
  int          t0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
    if (a != 5'd0) m[a] = d;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    t0 = cyc;
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit f = 1'b0;
    for (int i = 0; i < 800 && !f; i++) begin
      @(negedge CLK);
      f = DONE;
    end
    chk(tag, 64'(f), 64'd1);
    tick();
  endtask

  task automatic wait_read(input logic [4:0] a, input string tag);
    bit f = 1'b0;
    for (int i = 0; i < 200 && !f; i++) begin
      @(negedge CLK);
      f = BUSY && !OUT_VALID && (RA == a);
    end
    chk(tag, 64'(f), 64'd1);
  endtask

  task automatic wait_send(input logic [4:0] a, input string tag);
    bit f = 1'b0;
    for (int i = 0; i < 200 && !f; i++) begin
      @(negedge CLK);
      f = OUT_VALID && (OUT_ADDR == a);
    end
    chk(tag, 64'(f), 64'd1);
  endtask

  task automatic chk_dump(input int n0, input string tag);
    chk({tag, "_beats"}, 64'(qa.size() - n0), 64'd32);
    for (int i = 0; i < 32; i++) begin
      if (n0 + i < qa.size()) begin
        chk({tag, "_addr"}, 64'(qa[n0+i]), 64'(i));
        chk({tag, "_data"}, 64'(qd[n0+i]), 64'(m[i]));
      end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, 64'(OUT_VALID), 64'd0);
    chk({tag, "_busy"}, 64'(BUSY), 64'd0);
    chk({tag, "_done"}, 64'(DONE), 64'd0);
    chk({tag, "_ra"}, 64'(RA), 64'd0);
    chk({tag, "_oaddr"}, 64'(OUT_ADDR), 64'd0);
    chk({tag, "_odata"}, 64'(OUT_DATA), 64'd0);
  endtask

  initial begin
    int n0;
    int d0;
    int st;
    bit fin;
    logic [31:0] old3;

    for (int i = 0; i < 32; i++) m[i] = 32'd0;

    // reset state
    repeat (3) tick();
    @(negedge CLK);
    chk_reset_outs("rst");
    tick();
    RST = 1'b0;
    bank_clr = 1'b0;

    for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000_0000 + 32'(i));

    // full dump, ready tied high
    OUT_READY = 1'b1;
    n0 = qa.size();
    d0 = done_cnt;
    pulse_start();
    @(negedge CLK);
    chk("s1_ra_first", 64'(RA), 64'd0);
    chk("s1_busy", 64'(BUSY), 64'd1);
    wait_done("s1_done_seen");
    chk("s1_latency", 64'(done_cyc - t0), 64'd64);
    chk("s1_done_once", 64'(done_cnt - d0), 64'd1);
    chk_dump(n0, "s1");

    // random backpressure with 5-cycle stalls, START pulses while busy
    n0 = qa.size();
    d0 = done_cnt;
    pulse_start();
    st = 0;
    fin = 1'b0;
    for (int k = 0; k < 1500 && !fin; k++) begin
      if (st > 0) begin
        OUT_READY = 1'b0;
        st--;
      end else if ($urandom_range(0, 3) == 0) begin
        OUT_READY = 1'b0;
        st = 4;
      end else begin
        OUT_READY = 1'b1;
      end
      START = (k == 10) || (k == 11) || (k == 40);
      @(negedge CLK);
      fin = DONE;
      tick();
    end
    START = 1'b0;
    OUT_READY = 1'b1;
    chk("s2_done_seen", 64'(fin), 64'd1);
    chk("s2_done_once", 64'(done_cnt - d0), 64'd1);
    chk_dump(n0, "s2");
    if (qa.size() > 0) chk("s2_last_addr", 64'(qa[qa.size()-1]), 64'd31);
    repeat (4) tick();
    @(negedge CLK);
    chk("s2_idle_after", 64'(BUSY), 64'd0);
    tick();

    // abort in SEND of beat 5, coinciding with a handshake
    n0 = qa.size();
    d0 = done_cnt;
    pulse_start();
    wait_read(5'd5, "s4_reach5");
    tick();
    chk("s4_in_send", 64'(OUT_VALID), 64'd1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    @(negedge CLK);
    chk("s4_valid", 64'(OUT_VALID), 64'd0);
    chk("s4_busy", 64'(BUSY), 64'd0);
    chk("s4_ra", 64'(RA), 64'd0);
    repeat (4) tick();
    chk("s4_no_done", 64'(done_cnt - d0), 64'd0);
    chk("s4_beats", 64'(qa.size() - n0), 64'd6);
    n0 = qa.size();
    pulse_start();
    @(negedge CLK);
    chk("s4_restart_ra", 64'(RA), 64'd0);
    wait_done("s4_done_seen");
    chk_dump(n0, "s4r");

    // synchronous reset during a stalled SEND of beat 10
    n0 = qa.size();
    d0 = done_cnt;
    pulse_start();
    wait_read(5'd10, "s5_reach10");
    tick();
    OUT_READY = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk_reset_outs("s5");
    repeat (3) tick();
    chk("s5_beats", 64'(qa.size() - n0), 64'd10);
    chk("s5_no_done", 64'(done_cnt - d0), 64'd0);

    // write to reg3 on the edge that captures it
    n0 = qa.size();
    pulse_start();
    wait_send(5'd2, "s6_reach2");
    tick();
    chk("s6_read3_ra", 64'(RA), 64'd3);
    we = 1'b1; wa = 5'd3; wd = 32'hAAAA_5555;
    tick();
    we = 1'b0;
    old3 = m[3];
    wait_done("s6_done_seen");
    if (n0 + 3 < qa.size()) chk("s6_old3", 64'(qd[n0+3]), 64'(old3));
    m[3] = 32'hAAAA_5555;
    n0 = qa.size();
    pulse_start();
    wait_done("s6b_done_seen");
    chk_dump(n0, "s6b");

    // single-register window 7..7
    wr(5'd7, 32'hDEAD_BEEF);
    n0 = q7a.size();
    d0 = done7_cnt;
    START7 = 1'b1;
    tick();
    START7 = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < 50 && !fin; i++) begin
      @(negedge CLK);
      fin = DONE7;
    end
    chk("s3_done_seen", 64'(fin), 64'd1);
    repeat (4) tick();
    chk("s3_beats", 64'(q7a.size() - n0), 64'd1);
    if (q7a.size() > n0) begin
      chk("s3_addr", 64'(q7a[n0]), 64'd7);
      chk("s3_data", 64'(q7d[n0]), 64'hDEAD_BEEF);
    end
    chk("s3_done_once", 64'(done7_cnt - d0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
